// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: valid/ready character stream out of uart_rx_ctrl.
// master drives data/valid, slave drives ready.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] M_TDATA;
  logic                 M_TVALID;
  logic                 M_TREADY;

  modport master (
    output M_TDATA,
    output M_TVALID,
    input  M_TREADY
  );

  modport slave (
    input  M_TDATA,
    input  M_TVALID,
    output M_TREADY
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: rx character FWFT FIFO, sticky overrun, optional idle irq.
// Idle timer is built only when UART_RX_IDLE_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int OVERSAMPLING = 8,
  parameter int IDLE_BITS    = 16
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic                  DIVPULSE,
  input  logic                  ENABLE,
  input  logic                  RX_DRDY,
  input  logic [DATA_BITS-1:0]  RX_DO,
  input  logic                  RX_BUSY,
  uart_rx_ctrl_if.master        m,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                  OVERRUN,
  input  logic                  CLR_OVR,
  output logic                  IDLE_IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_nxt;
  logic [LW-1:0]        level;
  logic [DATA_BITS-1:0] tdata;
  logic [DATA_BITS-1:0] head_n;
  logic                 drdy_q;
  logic                 valid;
  logic                 full;
  logic                 push_ev;
  logic                 pop;
  logic                 do_push;
  logic                 drop;

  assign valid   = (level != '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign push_ev = RX_DRDY & ~drdy_q & ENABLE;
  assign pop     = valid & m.M_TREADY;
  assign do_push = push_ev & (~full | pop);
  assign drop    = push_ev & full & ~pop;
  assign rd_nxt  = rd_ptr + AW'(1);

  assign m.M_TDATA  = tdata;
  assign m.M_TVALID = valid;
  assign FIFO_LEVEL = level;

  // Next head: the slot behind the popped one, or the incoming char
  // when it lands in an empty (or just-emptied) FIFO.
  always_comb begin
    head_n = tdata;
    if (pop) begin
      if (level > LW'(1))
        head_n = mem[rd_nxt];
      else if (do_push)
        head_n = RX_DO;
    end else if (!valid && do_push) begin
      head_n = RX_DO;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr] <= RX_DO;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      tdata   <= '0;
      drdy_q  <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      drdy_q <= RX_DRDY;
      tdata  <= head_n;
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_nxt;
      unique case ({do_push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop)
        OVERRUN <= 1'b1;
      else if (CLR_OVR)
        OVERRUN <= 1'b0;
    end
  end

`ifdef UART_RX_IDLE_TIMEOUT_EN
  typedef enum logic [1:0] {
    T_OFF,
    T_ARMED,
    T_FIRE
  } tstate_t;

  localparam logic [15:0] LIMIT =
    16'(IDLE_BITS * OVERSAMPLING - 1);

  tstate_t     st;
  tstate_t     st_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      st  <= T_OFF;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    unique case (st)
      T_OFF: begin
        cnt_n = '0;
        if (do_push)
          st_n = T_ARMED;
      end
      T_ARMED: begin
        if (!ENABLE) begin
          st_n  = T_OFF;
          cnt_n = '0;
        end else if (do_push || RX_BUSY) begin
          cnt_n = '0;
        end else if (DIVPULSE) begin
          if (cnt == LIMIT) begin
            st_n  = T_FIRE;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      T_FIRE: begin
        cnt_n = '0;
        st_n  = do_push ? T_ARMED : T_OFF;
      end
      default: begin
        st_n  = T_OFF;
        cnt_n = '0;
      end
    endcase
  end

  always_comb IDLE_IRQ = (st == T_FIRE);
`else
  logic unused_timer_in;
  assign unused_timer_in = DIVPULSE ^ RX_BUSY;
  assign IDLE_IRQ = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller placed behind `uart_rx`. It takes each completed character from `RX_DRDY`/`RX_DO` and queues it in a small first-word-fall-through FIFO. It drains that FIFO to the consumer over a valid/ready stream, flags overrun, and optionally raises a line-idle interrupt after a configurable number of silent bit periods.

## Interface
- `DATA_BITS`, 8: character width; must match `uart_rx`.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `OVERSAMPLING`, 8: `DIVPULSE` ticks per bit; must match `uart_rx`.
- `IDLE_BITS`, 16: silent bit periods before `IDLE_IRQ`; ≥1.

- `CLK`  in  1  system clock, rising edge.
- `NRST`  in  1  asynchronous, active-low reset.
- `DIVPULSE`  in  1  oversampling tick from the baud generator, one `CLK` wide.
- `ENABLE`  in  1  high = accept characters; low = discard and disarm the idle timer.
- `RX_DRDY`  in  1  character-ready from `uart_rx`; may stay high for more than one cycle.
- `RX_DO`  in  DATA_BITS  received character; valid while `RX_DRDY` is high.
- `RX_BUSY`  in  1  receiver is mid-frame.
- `M_TDATA`  out  DATA_BITS  FIFO head.
- `M_TVALID`  out  1  FIFO not empty.
- `M_TREADY`  in  1  consumer accepts head.
- `FIFO_LEVEL`  out  $clog2(FIFO_DEPTH)+1  occupied entries, 0..FIFO_DEPTH.
- `OVERRUN`  out  1  sticky; a character was dropped because the FIFO was full.
- `CLR_OVR`  in  1  clears `OVERRUN`.
- `IDLE_IRQ`  out  1  single-cycle pulse on idle timeout; tied 0 when the timer is compiled out.

## Operation
- **Push event:** `RX_DRDY`=1 while the registered previous `RX_DRDY` is 0 (rising-edge detect) and `ENABLE`=1. One push per assertion, however long `RX_DRDY` stays high. `RX_DO` is written at the tail.
- **Pop event:** `M_TVALID & M_TREADY`. Head advances; the new head appears on `M_TDATA` the next cycle.
- **FIFO:** circular buffer. Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. `FIFO_LEVEL` is a separate up/down counter.
- **Full + push, no pop:** character dropped, pointers unchanged, `OVERRUN` set.
- **Full + push + pop in the same cycle:** both are performed, level stays `FIFO_DEPTH`, no overrun.
- **Empty + push + pop:** cannot occur, because `M_TVALID`=0 blocks the pop.
- **`OVERRUN`:** cleared by `CLR_OVR`. If a set and a clear occur in the same cycle, set wins.
- **`ENABLE`=0:** push events are ignored without setting `OVERRUN`. Queued data still drains.
- **Idle timer FSM:**
  - `T_OFF` → `T_ARMED` on a successful push.
  - `T_ARMED` → `T_OFF` when `ENABLE`=0.
  - `T_ARMED`: a 16-bit-wide tick counter clears while `RX_BUSY`=1 and increments on each `DIVPULSE` while `RX_BUSY`=0.
  - `T_ARMED` → `T_FIRE` when the counter reaches `IDLE_BITS*OVERSAMPLING-1` and a `DIVPULSE` arrives.
  - `T_FIRE`: `IDLE_IRQ`=1 for exactly one cycle, counter cleared, then → `T_OFF`.
  - A push in `T_ARMED` clears the counter.
  - The timer fires at most once per burst.

## Timing
- Reset (`NRST`=0, asynchronous):
  - Pointers and level are 0, giving `M_TVALID`=0 and `FIFO_LEVEL`=0.
  - `M_TDATA`=0, `OVERRUN`=0, `IDLE_IRQ`=0.
  - FSM = `T_OFF`, counter = 0, `RX_DRDY` edge register = 0.
  - FIFO storage is not reset.
- Reset applied mid-operation discards all queued data immediately. Deassertion is treated as synchronous to `CLK` by the upstream reset synchronizer.
- Push latency: a push sampled at edge *n* drives `M_TVALID`=1 and `FIFO_LEVEL` updated after edge *n*.
- `M_TDATA` is registered. It holds stable while `M_TVALID`=1 and `M_TREADY`=0.
- `OVERRUN` rises the cycle after the dropped push.
- `IDLE_IRQ` rises on the cycle after the qualifying `DIVPULSE`.

## Configuration
- `UART_RX_IDLE_TIMEOUT_EN` defined: idle-timer FSM and counter are instantiated as described.
- `UART_RX_IDLE_TIMEOUT_EN` undefined: timer logic is absent, `IDLE_IRQ` is constant 0, and `DIVPULSE`/`RX_BUSY` are unused. FIFO and overrun behaviour are identical in both builds.

## Test plan
- **Single character:** `RX_DRDY` pulses 3 cycles with `RX_DO`=0xA5, `M_TREADY`=0.
  - `FIFO_LEVEL`=1 and `M_TDATA`=0xA5 one cycle later.
  - Exactly one entry is pushed despite the 3-cycle pulse.
- **Fill and overrun:** push 0x01..0x05 into a `FIFO_DEPTH`=4 FIFO, no pops.
  - `FIFO_LEVEL`=4 and `OVERRUN`=1 after the 5th push.
  - Drain yields 0x01,0x02,0x03,0x04; `CLR_OVR` then clears `OVERRUN`.
- **Full push+pop:** with the FIFO full, push 0x06 in the same cycle as a pop.
  - Level stays 4 and `OVERRUN` stays 0.
  - Drain order is 0x02,0x03,0x04,0x06 (with 0x01 as the popped head).
- **Pointer wrap-around:** stream 0x00..0xFF with `M_TREADY` toggling every cycle.
  - All 256 values arrive in order with no loss.
- **Idle IRQ:** `OVERSAMPLING`=8, `IDLE_BITS`=2, one push, then `RX_BUSY`=0 with `DIVPULSE` every 4 cycles.
  - `IDLE_IRQ` pulses one cycle after the 16th `DIVPULSE`, and never again until the next push.
  - With the macro undefined, `IDLE_IRQ` stays 0.
- **Reset mid-stream:** `NRST` low for 1 cycle while 3 entries are queued and `OVERRUN`=1.
  - All outputs are 0 immediately.
  - The next push yields `FIFO_LEVEL`=1.
